// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage and the decoder: widths, NOOP encoding,
// instruction field positions and the fetch state type.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned INSTR_W = 24;

  localparam logic [INSTR_W-1:0] NOOP = 24'h000000;

  // Instruction field positions (Cond2 Op5 SF1 ...)
  localparam int unsigned COND_HI  = 23;
  localparam int unsigned COND_LO  = 22;
  localparam int unsigned OP_HI    = 21;
  localparam int unsigned OP_LO    = 17;
  localparam int unsigned SF_BIT   = 16;
  localparam int unsigned RD_HI    = 15;
  localparam int unsigned RD_LO    = 13;
  localparam int unsigned RS_HI    = 12;
  localparam int unsigned RS_LO    = 10;
  localparam int unsigned RT_HI    = 9;
  localparam int unsigned RT_LO    = 7;
  localparam int unsigned IMM10_HI = 9;
  localparam int unsigned IMM10_LO = 0;
  localparam int unsigned IMM17_HI = 16;
  localparam int unsigned IMM17_LO = 0;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

  function automatic logic [1:0] instr_cond(input logic [INSTR_W-1:0] instr);
    return instr[COND_HI:COND_LO];
  endfunction

  function automatic logic [4:0] instr_op(input logic [INSTR_W-1:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction

  function automatic logic [2:0] instr_rd(input logic [INSTR_W-1:0] instr);
    return instr[RD_HI:RD_LO];
  endfunction

  function automatic logic [2:0] instr_rs(input logic [INSTR_W-1:0] instr);
    return instr[RS_HI:RS_LO];
  endfunction

  function automatic logic [2:0] instr_rt(input logic [INSTR_W-1:0] instr);
    return instr[RT_HI:RT_LO];
  endfunction

  function automatic logic [9:0] instr_imm10(input logic [INSTR_W-1:0] instr);
    return instr[IMM10_HI:IMM10_LO];
  endfunction

  function automatic logic [16:0] instr_imm17(input logic [INSTR_W-1:0] instr);
    return instr[IMM17_HI:IMM17_LO];
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: captures a fetched instruction with its PC and link value,
// or is flushed to a NOOP bubble; otherwise holds.
module if_id_reg #(
  parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
  parameter int unsigned INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [ADDR_W-1:0]  pc_plus1,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus1,
  output logic               id_valid
);
  import cpu_pkg::*;

  // Flush keeps id_pc/id_pc_plus1 so the bubble still carries the last real PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_instr    <= INSTR_W'(NOOP);
      id_pc       <= '0;
      id_pc_plus1 <= '0;
      id_valid    <= 1'b0;
    end else if (flush) begin
      id_instr <= INSTR_W'(NOOP);
      id_valid <= 1'b0;
    end else if (load) begin
      id_instr    <= instr;
      id_pc       <= pc;
      id_pc_plus1 <= pc_plus1;
      id_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory, fills the IF/ID
// register and counts captured instructions, with stall, redirect and halt control.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned       INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  input  logic               halt_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus1,
  output logic               id_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);
  import cpu_pkg::*;

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next_seq;
  logic              running;
  logic              load;
  logic              flush;

  assign pc_next_seq = pc + ADDR_W'(1);
  assign imem_addr   = pc;
  assign halted      = (state == S_HALT);
  assign running     = (state == S_RUN);

  // Priority in S_RUN: halt_req > redirect_valid > stall > normal fetch.
  always_comb begin
    flush = 1'b0;
    load  = 1'b0;
    if (running) begin
      flush = halt_req | redirect_valid;
      load  = ~halt_req & ~redirect_valid & ~stall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      fetch_count <= '0;
    end else begin
      case (state)
        S_BOOT: state <= S_RUN;
        S_RUN: begin
          if (halt_req) begin
            state <= S_HALT;
          end else if (redirect_valid) begin
            pc <= redirect_target;
          end else if (!stall) begin
            pc          <= pc_next_seq;
            fetch_count <= fetch_count + CNT_W'(1);
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_BOOT;
      endcase
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .flush      (flush),
    .instr      (imem_instr),
    .pc         (pc),
    .pc_plus1   (pc_next_seq),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc_plus1(id_pc_plus1),
    .id_valid   (id_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized control
// stimulus compared against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, redirect_valid, halt_req;
  logic [23:0] redirect_target;
  logic [23:0] imem_addr, imem_instr, id_instr, id_pc, id_pc_plus1;
  logic        id_valid, halted;
  logic [31:0] fetch_count;

  logic [23:0] w_imem_addr, w_imem_instr, w_id_instr, w_id_pc, w_id_pc_plus1;
  logic        w_id_valid, w_halted;
  logic [31:0] w_fetch_count;

  logic [23:0] mem [64];
  assign imem_instr   = mem[imem_addr[5:0]];
  assign w_imem_instr = mem[w_imem_addr[5:0]];

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .halt_req(halt_req), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus1(id_pc_plus1),
    .id_valid(id_valid), .halted(halted), .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_PC(24'hFFFFFF)) dut_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_target(24'h000000), .halt_req(1'b0), .imem_addr(w_imem_addr),
    .imem_instr(w_imem_instr), .id_instr(w_id_instr), .id_pc(w_id_pc),
    .id_pc_plus1(w_id_pc_plus1), .id_valid(w_id_valid), .halted(w_halted),
    .fetch_count(w_fetch_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural view of the fetch stage.
  logic [23:0] m_pc, m_instr, m_idpc, m_idpc1;
  logic        m_valid, m_halted, m_booting;
  logic [31:0] m_count;

  task automatic model_edge();
    if (rst) begin
      m_pc = 24'h0; m_instr = 24'h0; m_idpc = 24'h0; m_idpc1 = 24'h0;
      m_valid = 1'b0; m_count = 0; m_halted = 1'b0; m_booting = 1'b1;
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (halt_req) begin
      m_halted = 1'b1; m_valid = 1'b0; m_instr = 24'h0;
    end else if (redirect_valid) begin
      m_pc = redirect_target; m_valid = 1'b0; m_instr = 24'h0;
    end else if (!stall) begin
      m_instr = mem[m_pc % 64];
      m_idpc  = m_pc;
      m_idpc1 = (m_pc + 1) % (1 << 24);
      m_pc    = (m_pc + 1) % (1 << 24);
      m_valid = 1'b1;
      m_count = m_count + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; redirect_valid = 0; halt_req = 0; redirect_target = 24'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_id_valid got %b want 0", id_valid); end
    n_cmp++; if (fetch_count !== 32'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", fetch_count); end
    n_cmp++; if (imem_addr !== 24'h0) begin n_bad++; $display("FAIL reset_pc got %h want 000000", imem_addr); end
    n_cmp++; if (id_instr !== 24'h0 || id_pc !== 24'h0 || id_pc_plus1 !== 24'h0 || halted !== 1'b0) begin
      n_bad++; $display("FAIL reset_id_regs got instr=%h pc=%h pc1=%h halted=%b want all 0", id_instr, id_pc, id_pc_plus1, halted);
    end
  endtask

  task automatic test_boot_run();
    do_reset();
    tick();
    n_cmp++; if (id_valid !== 1'b0 || imem_addr !== 24'h0) begin
      n_bad++; $display("FAIL boot_cycle got valid=%b pc=%h want 0/000000", id_valid, imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 24'(i) || id_pc_plus1 !== 24'(i + 1)) begin
        n_bad++; $display("FAIL run_id_pc got valid=%b pc=%h pc1=%h want 1/%h/%h", id_valid, id_pc, id_pc_plus1, 24'(i), 24'(i + 1));
      end
      if (i == 1) begin
        n_cmp++; if (id_instr !== 24'h002980) begin n_bad++; $display("FAIL run_and_instr got %h want 002980", id_instr); end
      end
    end
    n_cmp++; if (fetch_count !== 32'd4 || imem_addr !== 24'd4) begin
      n_bad++; $display("FAIL run_count got count=%0d pc=%h want 4/000004", fetch_count, imem_addr);
    end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    for (int i = 0; i < 4; i++) tick();   // boot + fetch 0,1,2 -> pc=3
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (imem_addr !== 24'd3 || id_pc !== 24'd2 || id_valid !== 1'b1 || fetch_count !== 32'd3 || id_instr !== mem[2]) begin
        n_bad++; $display("FAIL stall_hold got pc=%h id_pc=%h valid=%b cnt=%0d instr=%h want 3/2/1/3/%h", imem_addr, id_pc, id_valid, fetch_count, id_instr, mem[2]);
      end
    end
    stall = 0;
    tick();
    n_cmp++; if (id_pc !== 24'd3 || id_instr !== mem[3] || fetch_count !== 32'd4) begin
      n_bad++; $display("FAIL stall_release got id_pc=%h instr=%h cnt=%0d want 3/%h/4", id_pc, id_instr, fetch_count, mem[3]);
    end
    tick();                                // pc=5
    stall = 1; redirect_valid = 1; redirect_target = 24'd15;
    tick();
    n_cmp++; if (id_valid !== 1'b0 || id_instr !== 24'h0 || imem_addr !== 24'd15 || id_pc !== 24'd4 || fetch_count !== 32'd5) begin
      n_bad++; $display("FAIL redirect_flush got valid=%b instr=%h pc=%h id_pc=%h cnt=%0d want 0/0/f/4/5", id_valid, id_instr, imem_addr, id_pc, fetch_count);
    end
    idle_inputs();
    tick();
    n_cmp++; if (id_pc !== 24'd15 || id_pc_plus1 !== 24'd16 || id_valid !== 1'b1 || id_instr !== mem[15]) begin
      n_bad++; $display("FAIL redirect_target got id_pc=%h pc1=%h valid=%b instr=%h want f/10/1/%h", id_pc, id_pc_plus1, id_valid, id_instr, mem[15]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    n_cmp++; if (w_imem_addr !== 24'hFFFFFF) begin n_bad++; $display("FAIL wrap_reset_pc got %h want ffffff", w_imem_addr); end
    tick(); tick();
    n_cmp++; if (w_id_pc !== 24'hFFFFFF || w_id_pc_plus1 !== 24'h0 || w_imem_addr !== 24'h0 || w_id_instr !== mem[63] || w_fetch_count !== 32'd1) begin
      n_bad++; $display("FAIL wrap got id_pc=%h pc1=%h pc=%h instr=%h cnt=%0d want ffffff/0/0/%h/1", w_id_pc, w_id_pc_plus1, w_imem_addr, w_id_instr, w_fetch_count, mem[63]);
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 8; i++) tick();   // boot + 7 fetches -> pc=7
    halt_req = 1;
    tick();
    n_cmp++; if (halted !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 24'd7 || id_instr !== 24'h0) begin
      n_bad++; $display("FAIL halt_enter got halted=%b valid=%b pc=%h instr=%h want 1/0/7/0", halted, id_valid, imem_addr, id_instr);
    end
    halt_req = 0; redirect_valid = 1; redirect_target = 24'd0;
    tick(); tick();
    n_cmp++; if (halted !== 1'b1 || imem_addr !== 24'd7 || fetch_count !== 32'd7 || id_valid !== 1'b0) begin
      n_bad++; $display("FAIL halt_ignore got halted=%b pc=%h cnt=%0d valid=%b want 1/7/7/0", halted, imem_addr, fetch_count, id_valid);
    end
    redirect_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    n_cmp++; if (halted !== 1'b0 || imem_addr !== 24'd0 || fetch_count !== 32'd0) begin
      n_bad++; $display("FAIL halt_exit got halted=%b pc=%h cnt=%0d want 0/0/0", halted, imem_addr, fetch_count);
    end
    tick();
    n_cmp++; if (id_valid !== 1'b0 || imem_addr !== 24'd0) begin
      n_bad++; $display("FAIL halt_reboot got valid=%b pc=%h want 0/0", id_valid, imem_addr);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    stall = 1;
    tick();
    n_cmp++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL midstall_pre got valid=%b want 1", id_valid); end
    rst = 1; redirect_valid = 1; redirect_target = 24'd40;
    tick();
    n_cmp++; if (id_valid !== 1'b0 || fetch_count !== 32'd0 || imem_addr !== 24'd0) begin
      n_bad++; $display("FAIL midstall_reset got valid=%b cnt=%0d pc=%h want 0/0/0", id_valid, fetch_count, imem_addr);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst             = ($urandom_range(0, 149) == 0);
      stall           = ($urandom_range(0, 3) == 0);
      redirect_valid  = ($urandom_range(0, 7) == 0);
      halt_req        = ($urandom_range(0, 99) == 0);
      redirect_target = ($urandom_range(0, 9) == 0) ? 24'($urandom) : 24'($urandom_range(0, 63));
      tick();
      n_cmp++;
      if (imem_addr !== m_pc || id_instr !== m_instr || id_pc !== m_idpc || id_pc_plus1 !== m_idpc1 ||
          id_valid !== m_valid || halted !== m_halted || fetch_count !== m_count) begin
        n_bad++;
        $display("FAIL random_cycle%0d got pc=%h instr=%h id_pc=%h pc1=%h v=%b h=%b cnt=%0d want pc=%h instr=%h id_pc=%h pc1=%h v=%b h=%b cnt=%0d",
                 c, imem_addr, id_instr, id_pc, id_pc_plus1, id_valid, halted, fetch_count,
                 m_pc, m_instr, m_idpc, m_idpc1, m_valid, m_halted, m_count);
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 24'($urandom);
    mem[1] = 24'h002980;
    idle_inputs();
    test_reset();
    test_boot_run();
    test_stall_redirect();
    test_wrap();
    test_halt();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of the 24-bit instruction memory. It owns the PC and drives the memory address combinationally. It captures the returned 24-bit instruction into an IF/ID pipeline register for the decoder. It handles stall, branch/jump redirect (flush), halt and a retired-fetch counter.

Parameters:
ADDR_W, 24, PC / instruction-memory address width
INSTR_W, 24, instruction width (Cond2 Op5 SF1 ... format)
RESET_PC, 0, PC value loaded on reset
CNT_W, 32, width of fetch counter

Ports:
clk  input  1  single system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hold PC and IF/ID register (downstream hazard)
redirect_valid  input  1  taken branch/jump/JR this cycle
redirect_target  input  ADDR_W  new PC on redirect
halt_req  input  1  stop fetching until next reset
imem_addr  output  ADDR_W  address to instruction memory, = pc (combinational)
imem_instr  input  INSTR_W  instruction returned combinationally by memory
id_instr  output  INSTR_W  IF/ID instruction
id_pc  output  ADDR_W  PC of id_instr
id_pc_plus1  output  ADDR_W  id_pc+1 mod 2^ADDR_W (link value for call-type J)
id_valid  output  1  id_instr is a real fetched instruction
halted  output  1  state is S_HALT
fetch_count  output  CNT_W  number of instructions captured into IF/ID

Behaviour:
- Reset (rst=1 at edge, overrides everything, any state): pc<=RESET_PC; id_instr<=NOOP (24'h000000); id_pc<=0; id_pc_plus1<=0; id_valid<=0; fetch_count<=0; state<=S_BOOT.
- States: S_BOOT, S_RUN, S_HALT. halted=1 only in S_HALT.
- S_BOOT: one cycle. No capture, pc unchanged, then go to S_RUN unconditionally. Inputs are ignored.
- S_RUN, priority per edge: halt_req > redirect_valid > stall > normal.
  - halt_req: state<=S_HALT; id_valid<=0; id_instr<=NOOP; pc held.
  - redirect_valid: pc<=redirect_target; id_valid<=0; id_instr<=NOOP; id_pc/id_pc_plus1 hold; count holds. The redirect wins even if stall=1. The instruction at the old pc is discarded.
  - stall (no redirect): pc, id_*, count all hold.
  - normal: id_instr<=imem_instr; id_pc<=pc; id_pc_plus1<=pc+1; id_valid<=1; pc<=pc+1; fetch_count<=fetch_count+1.
- S_HALT: all registers hold. stall, redirect_valid and halt_req are ignored. The only exit is rst.
- Latency: the instruction at address A appears on id_instr on the edge after pc==A with no stall/redirect. Throughput is 1 instruction/cycle.
- Arithmetic: pc+1 wraps modulo 2^ADDR_W (24'hFFFFFF -> 0). fetch_count wraps modulo 2^CNT_W and has no saturation.
- imem_addr reflects pc in every state, including reset and halt.
- No X on outputs after the first reset edge.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W/INSTR_W constants
  - NOOP encoding 24'h000000
  - instruction field positions (Cond[23:22], Op[21:17], SF[16], Rd/Rt[15:13], Rs[12:10], Rt[9:7], Imm10[9:0], Imm17[16:0])
  - fetch state enum {S_BOOT, S_RUN, S_HALT}
- The decoder reuses the same package.
- One natural sub-module: if_id_reg, which holds id_instr/id_pc/id_pc_plus1/id_valid with load/flush/hold controls. PC and FSM stay in fetch_unit.

Test Plan:
- Reset, then run 5 cycles with the real memory:
  - id_valid goes 0 (boot), then 1.
  - id_pc goes 0, 1, 2, 3.
  - id_instr at id_pc=1 is 24'h002980 (AND R1,R2,R3).
  - fetch_count=4.
- stall=1 for 3 cycles when pc=3: imem_addr stays 3, and id_* and fetch_count are unchanged. The next free cycle captures pc=3.
- redirect_valid=1, target=15, with stall=1 at pc=5:
  - Next cycle: id_valid=0, id_instr=0, pc=15.
  - Following cycle: id_pc=15, id_pc_plus1=16.
- Wrap: RESET_PC=24'hFFFFFF. After boot plus one fetch, id_pc=24'hFFFFFF, id_pc_plus1=0 and pc=0.
- halt_req=1 at pc=7:
  - halted=1, id_valid=0, pc stays 7.
  - A later redirect to 0 is ignored.
  - rst returns the block to S_BOOT with pc=RESET_PC.
- rst asserted mid-stall with id_valid=1: the next edge gives id_valid=0, fetch_count=0 and pc=RESET_PC, regardless of stall/redirect.
